timer_ctrl: RTL and testbench
=============================

# timer_ctrl

Programmable timer controller that sequences a prescaler and a down-counter and emits clock-enable ticks plus a completion pulse. It replaces ad-hoc divided clocks in the lab designs: downstream flip-flops stay on `clk` and gate their updates with `tick`. Software-style configuration uses a valid/ready handshake, and a four-state FSM gives one-shot or periodic operation with start and stop control.

## Interface
- `WIDTH`, default 8: width of the period and count.
- `PRESCALE_W`, default 4: width of the prescale value.
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `cfg_valid`  in  1  configuration offered this cycle.
- `cfg_ready`  out  1  configuration accepted when high together with `cfg_valid`.
- `cfg_period`  in  WIDTH  number of ticks per run (M).
- `cfg_prescale`  in  PRESCALE_W  prescale value P; ticks occur every P+1 cycles.
- `cfg_periodic`  in  1  1 = auto-reload, 0 = one-shot.
- `start`  in  1  begin a run (level sampled on each edge).
- `stop`  in  1  abort the run.
- `tick`  out  1  one-cycle clock-enable pulse.
- `done`  out  1  one-cycle pulse, coincident with the final tick of each run.
- `busy`  out  1  high while in state RUN.
- `count`  out  WIDTH  ticks remaining in the current run.

## Operation
- **States:** IDLE, ARMED, RUN, DONE. Registers: `period_q`, `pre_q`, `periodic_q`, `cnt` (WIDTH), `pre_cnt` (PRESCALE_W).
- **cfg_ready:** equals 1 in IDLE, ARMED and DONE; equals 0 in RUN, where `cfg_valid` is ignored.
- **Accepted config:** latches period, prescale and periodic. Sets `cnt` to `cfg_period` and the next state to ARMED.
- **ARMED:**
  - `start` with `period_q` not equal to 0: go to RUN, `pre_cnt` set to 0, `cnt` set to `period_q`.
  - `start` with `period_q` equal to 0: ignored; stay ARMED.
- **RUN:**
  - If `pre_cnt` equals `pre_q`, `pre_cnt` wraps to 0; otherwise it increments by 1.
  - `tick` = (state is RUN) and (`pre_cnt` equals `pre_q`). This is combinational from registers.
  - On a tick edge, `cnt` decrements by 1.
  - `done` = `tick` and (`cnt` equals 1).
  - When `done` is high and periodic: `cnt` reloads to `period_q` and the state stays RUN.
  - When `done` is high and one-shot: `cnt` becomes 0 and the state becomes DONE.
  - `stop` in RUN: go to ARMED, `cnt` reloads to `period_q`, `pre_cnt` set to 0. A tick and done in that same cycle are still output, but the reload and ARMED take priority.
- **DONE:**
  - `start` (with `period_q` not equal to 0): go to RUN, with `cnt` and `pre_cnt` reloaded as from ARMED.
  - An accepted config: go to ARMED.
- **Priorities:**
  - `stop` beats `start`.
  - In ARMED or DONE, an accepted config beats `start`. The new values are latched, the state becomes ARMED, and `start` is ignored that cycle.
  - `stop` outside RUN has no effect.
- **busy:** (state is RUN).
- **count:** outputs `cnt`. It reads 0 in IDLE, `period_q` in ARMED, and 0 in DONE after a one-shot run.
- **Arithmetic:** all counters are unsigned and never wrap below 0. `cnt` is only decremented while it is at least 1.

## Timing
- **Reset (asynchronous, immediate):**
  - state = IDLE; `cnt`, `pre_cnt`, `period_q`, `pre_q`, `periodic_q` = 0.
  - Outputs: `tick`=0, `done`=0, `busy`=0, `count`=0, `cfg_ready`=1.
- **Start latency:** `start` sampled at the edge ending cycle N puts the FSM in RUN from cycle N+1.
- **Tick schedule:** ticks occur in cycles N+1+P+k(P+1), for k = 0..M-1.
- **Completion:** `done` occurs in cycle N+M(P+1). A one-shot FSM is in DONE from cycle N+M(P+1)+1, with `busy` low.
- **P=0:** `tick` is high in every RUN cycle.
- **Periodic mode:** `done` repeats every M(P+1) cycles with no gap cycle between runs.
- **Config latency:** a config accepted at edge E is visible on `count` in the cycle after E.
- **Reset mid-run:** outputs drop within the reset assertion with no extra `tick` or `done`. After release, the FSM starts from IDLE.

## Test plan
- **One-shot:** config M=3, P=2, periodic=0. Start sampled at cycle 10 → `tick` in cycles 13, 16, 19; `done` in cycle 19 only; `busy` high cycles 11–19; state DONE and `count`=0 from cycle 20.
- **Periodic:** config M=2, P=1, periodic=1. Start sampled at cycle 5 → `tick` in cycles 7, 9, 11, 13…; `done` in cycles 9, 13, 17; `count` sequence 2, 1, 2, 1.
- **Stop mid-run:** M=4, P=0. Start sampled at cycle 0, stop sampled at cycle 2 → ticks in cycles 1 and 2; state ARMED in cycle 3 with `count`=4 and `busy`=0. Start and stop together → stop wins and the state stays ARMED.
- **Config handshake:** `cfg_valid` held high during RUN → `cfg_ready`=0 and period unchanged. In DONE, config M=5 together with `start` → `cfg_ready`=1, state ARMED, `count`=5, and no tick in the following cycle.
- **Period 0:** config M=0 then `start` → state stays ARMED and `tick`/`busy` stay 0. The reconfiguration sequence from M=0 to M=1, P=0, then start at cycle N → single `tick`+`done` in cycle N+1.
- **Asynchronous reset:** `rst` pulsed mid-cycle during RUN → `tick`, `busy`, `count` go to 0 without waiting for a clock edge; `cfg_ready`=1. After release, `start` is ignored until a config has been accepted.

Source files
------------

// File: rtl/timer_ctrl.sv
// Prescaled down-counting timer: emits one-cycle clock-enable ticks and a
// done pulse on the final tick, with one-shot or auto-reload operation.
module timer_ctrl #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [WIDTH-1:0]      cfg_period,
  input  logic [PRESCALE_W-1:0] cfg_prescale,
  input  logic                  cfg_periodic,
  input  logic                  start,
  input  logic                  stop,
  output logic                  tick,
  output logic                  done,
  output logic                  busy,
  output logic [WIDTH-1:0]      count,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q;
  logic [WIDTH-1:0]      cnt_q;
  logic [PRESCALE_W-1:0] pre_cnt_q;
  logic [WIDTH-1:0]      period_q;
  logic [PRESCALE_W-1:0] pre_q;
  logic                  periodic_q;

  logic tick_w;
  logic done_w;
  logic cfg_acc;
  logic can_start;

  // Handshake: a config transfers on any edge where cfg_valid && cfg_ready;
  // cfg_ready is low only in RUN, so configs offered then are simply dropped.
  assign cfg_acc   = cfg_valid && (state_q != S_RUN);
  assign can_start = start && !stop && (period_q != '0);
  assign tick_w    = (state_q == S_RUN) && (pre_cnt_q == pre_q);
  assign done_w    = tick_w && (cnt_q == WIDTH'(1));

  assign tick      = tick_w;
  assign done      = done_w;
  assign busy      = (state_q == S_RUN);
  assign cfg_ready = (state_q != S_RUN);
  assign count     = cnt_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pre_cnt_q  <= '0;
      period_q   <= '0;
      pre_q      <= '0;
      periodic_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cfg_acc) begin
            period_q   <= cfg_period;
            pre_q      <= cfg_prescale;
            periodic_q <= cfg_periodic;
            cnt_q      <= cfg_period;
            state_q    <= S_ARMED;
          end
        end
        // A new config wins over start; a zero period can never be started.
        S_ARMED, S_DONE: begin
          if (cfg_acc) begin
            period_q   <= cfg_period;
            pre_q      <= cfg_prescale;
            periodic_q <= cfg_periodic;
            cnt_q      <= cfg_period;
            state_q    <= S_ARMED;
          end else if (can_start) begin
            cnt_q     <= period_q;
            pre_cnt_q <= '0;
            state_q   <= S_RUN;
          end
        end
        S_RUN: begin
          if (stop) begin
            cnt_q     <= period_q;
            pre_cnt_q <= '0;
            state_q   <= S_ARMED;
          end else begin
            if (pre_cnt_q == pre_q) begin
              pre_cnt_q <= '0;
            end else begin
              pre_cnt_q <= pre_cnt_q + PRESCALE_W'(1);
            end
            if (done_w) begin
              if (periodic_q) begin
                cnt_q <= period_q;
              end else begin
                cnt_q   <= '0;
                state_q <= S_DONE;
              end
            end else if (tick_w && (cnt_q != '0)) begin
              cnt_q <= cnt_q - WIDTH'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed vector bench for timer_ctrl: a table of per-cycle inputs and
// hand-computed outputs, plus an asynchronous-reset sequence.
`timescale 1ns/1ps
module tb_timer_ctrl;

  localparam int WIDTH      = 8;
  localparam int PRESCALE_W = 4;
  localparam logic [1:0] ST_I = 2'd0;
  localparam logic [1:0] ST_A = 2'd1;
  localparam logic [1:0] ST_R = 2'd2;
  localparam logic [1:0] ST_D = 2'd3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [WIDTH-1:0]      cfg_period;
  logic [PRESCALE_W-1:0] cfg_prescale;
  logic                  cfg_periodic;
  logic                  start;
  logic                  stop;
  logic                  tick;
  logic                  done;
  logic                  busy;
  logic [WIDTH-1:0]      count;
  logic [1:0]            dbg_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic                  cv;
    logic [WIDTH-1:0]      cp;
    logic [PRESCALE_W-1:0] cps;
    logic                  cper;
    logic                  st;
    logic                  sp;
    logic                  e_tick;
    logic                  e_done;
    logic                  e_busy;
    logic [WIDTH-1:0]      e_count;
    logic                  e_ready;
    logic [1:0]            e_state;
  } vec_t;

  vec_t vecs[$];

  timer_ctrl #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_prescale(cfg_prescale), .cfg_periodic(cfg_periodic),
    .start(start), .stop(stop),
    .tick(tick), .done(done), .busy(busy), .count(count),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic e_tick, input logic e_done, input logic e_busy,
                           input logic [WIDTH-1:0] e_count, input logic e_ready, input logic [1:0] e_state);
    check("tick", idx, 32'(tick), 32'(e_tick));
    check("done", idx, 32'(done), 32'(e_done));
    check("busy", idx, 32'(busy), 32'(e_busy));
    check("count", idx, 32'(count), 32'(e_count));
    check("cfg_ready", idx, 32'(cfg_ready), 32'(e_ready));
    check("state", idx, 32'(dbg_state), 32'(e_state));
  endtask

  function automatic void add(input int cv, input int cp, input int cps, input int cper,
                              input int st, input int sp, input int tk, input int dn,
                              input int bz, input int cnt, input int rdy, input logic [1:0] s);
    vec_t v;
    v.cv = cv[0]; v.cp = cp[WIDTH-1:0]; v.cps = cps[PRESCALE_W-1:0]; v.cper = cper[0];
    v.st = st[0]; v.sp = sp[0]; v.e_tick = tk[0]; v.e_done = dn[0]; v.e_busy = bz[0];
    v.e_count = cnt[WIDTH-1:0]; v.e_ready = rdy[0]; v.e_state = s;
    vecs.push_back(v);
  endfunction

  // driver: inputs for one cycle, outputs checked mid-cycle, then the edge
  task automatic apply(input vec_t v, input int idx);
    cfg_valid = v.cv; cfg_period = v.cp; cfg_prescale = v.cps; cfg_periodic = v.cper;
    start = v.st; stop = v.sp;
    @(negedge clk);
    check_all(idx, v.e_tick, v.e_done, v.e_busy, v.e_count, v.e_ready, v.e_state);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    cfg_valid = 1'b0; cfg_period = '0; cfg_prescale = '0; cfg_periodic = 1'b0;
    start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    //    cv cp cps per st sp | tk dn bz cnt rdy state
    // one-shot M=3 P=2, cfg offered during RUN is dropped
    add(1, 3, 2, 0, 0, 0,  0, 0, 0, 0, 1, ST_I);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 3, 1, ST_A);
    add(0, 0, 0, 0, 1, 0,  0, 0, 0, 3, 1, ST_A);
    add(0, 0, 0, 0, 0, 0,  0, 0, 1, 3, 0, ST_R);
    add(0, 0, 0, 0, 0, 0,  0, 0, 1, 3, 0, ST_R);
    add(0, 0, 0, 0, 0, 0,  1, 0, 1, 3, 0, ST_R);
    add(1, 7, 0, 1, 0, 0,  0, 0, 1, 2, 0, ST_R);
    add(1, 7, 0, 1, 0, 0,  0, 0, 1, 2, 0, ST_R);
    add(0, 0, 0, 0, 0, 0,  1, 0, 1, 2, 0, ST_R);
    add(0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, ST_R);
    add(0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, ST_R);
    add(0, 0, 0, 0, 0, 0,  1, 1, 1, 1, 0, ST_R);
    // DONE: config M=5 together with start -> ARMED, no tick
    add(1, 5, 0, 0, 1, 0,  0, 0, 0, 0, 1, ST_D);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 5, 1, ST_A);
    // periodic M=2 P=1, stop on a tick cycle
    add(1, 2, 1, 1, 0, 0,  0, 0, 0, 5, 1, ST_A);
    add(0, 0, 0, 0, 1, 0,  0, 0, 0, 2, 1, ST_A);
    add(0, 0, 0, 0, 0, 0,  0, 0, 1, 2, 0, ST_R);
    add(0, 0, 0, 0, 0, 0,  1, 0, 1, 2, 0, ST_R);
    add(0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, ST_R);
    add(0, 0, 0, 0, 0, 0,  1, 1, 1, 1, 0, ST_R);
    add(0, 0, 0, 0, 0, 0,  0, 0, 1, 2, 0, ST_R);
    add(0, 0, 0, 0, 0, 0,  1, 0, 1, 2, 0, ST_R);
    add(0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, ST_R);
    add(0, 0, 0, 0, 0, 0,  1, 1, 1, 1, 0, ST_R);
    add(0, 0, 0, 0, 0, 0,  0, 0, 1, 2, 0, ST_R);
    add(0, 0, 0, 0, 0, 1,  1, 0, 1, 2, 0, ST_R);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 2, 1, ST_A);
    // stop mid-run M=4 P=0, then start+stop together
    add(1, 4, 0, 0, 0, 0,  0, 0, 0, 2, 1, ST_A);
    add(0, 0, 0, 0, 1, 0,  0, 0, 0, 4, 1, ST_A);
    add(0, 0, 0, 0, 0, 0,  1, 0, 1, 4, 0, ST_R);
    add(0, 0, 0, 0, 0, 1,  1, 0, 1, 3, 0, ST_R);
    add(0, 0, 0, 0, 1, 1,  0, 0, 0, 4, 1, ST_A);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 4, 1, ST_A);
    // period 0 cannot start; then M=1 P=0 gives a single tick+done
    add(1, 0, 0, 0, 0, 0,  0, 0, 0, 4, 1, ST_A);
    add(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 1, ST_A);
    add(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 1, ST_A);
    add(1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1, ST_A);
    add(0, 0, 0, 0, 1, 0,  0, 0, 0, 1, 1, ST_A);
    add(0, 0, 0, 0, 0, 0,  1, 1, 1, 1, 0, ST_R);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, ST_D);

    rst = 1'b1;
    drive_idle();
    #2;
    check_all(-1, 1'b0, 1'b0, 1'b0, '0, 1'b1, ST_I);
    @(posedge clk);
    #1;
    check_all(-2, 1'b0, 1'b0, 1'b0, '0, 1'b1, ST_I);
    rst = 1'b0;

    foreach (vecs[i]) apply(vecs[i], i);

    // asynchronous reset in the middle of a periodic run
    cfg_valid = 1'b1; cfg_period = 8'd3; cfg_prescale = '0; cfg_periodic = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    check("pre_rst_tick", 100, 32'(tick), 32'd1);
    check("pre_rst_count", 100, 32'(count), 32'd3);
    rst = 1'b1;
    #1;
    check_all(101, 1'b0, 1'b0, 1'b0, '0, 1'b1, ST_I);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start = 1'b1;
      @(negedge clk);
      check_all(110 + k, 1'b0, 1'b0, 1'b0, '0, 1'b1, ST_I);
      @(posedge clk); #1;
    end
    start = 1'b0; cfg_valid = 1'b1; cfg_period = 8'd1; cfg_prescale = '0; cfg_periodic = 1'b0;
    @(negedge clk);
    check_all(120, 1'b0, 1'b0, 1'b0, '0, 1'b1, ST_I);
    @(posedge clk); #1;
    cfg_valid = 1'b0; start = 1'b1;
    @(negedge clk);
    check_all(121, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, ST_A);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_all(122, 1'b1, 1'b1, 1'b1, 8'd1, 1'b0, ST_R);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
